// File: rtl/fuzz_round_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  fuzz_seq_pkg
//  Shared state encoding and round-status codes for the fuzz round sequencer.
//  Revision: 1.0
// ============================================================================
package fuzz_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RST    = 3'd1,
        RUN    = 3'd2,
        REPORT = 3'd3,
        RELOAD = 3'd4,
        HALT   = 3'd5
    } seq_state_t;

    localparam logic [2:0] ST_NONE    = 3'd0;
    localparam logic [2:0] ST_PASS    = 3'd1;
    localparam logic [2:0] ST_TIMEOUT = 3'd5;

    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fuzz_round_sequencer_stall_watchdog.sv
`default_nettype none
// ============================================================================
//  stall_watchdog
//  Coverage-stall and tohost watchdog counters driving the DUT interrupt.
//  Revision: 1.0
// ============================================================================
module stall_watchdog #(
    parameter int COV_W       = 30,
    parameter int MAX_WAIT    = 1000,
    parameter int STALL_SHIFT = 19,
    parameter int WDOG_LIMIT  = 50000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run_en,
    input  logic             tohost_done,
    input  logic [COV_W-1:0] cov,
    output logic             interrupt
);

    logic [COV_W-1:0] r_pre_cov;
    logic [31:0]      r_stall;
    logic [31:0]      r_wdog;
    logic             r_irq;

    logic [31:0]      w_stall_next;
    logic [31:0]      w_wdog_next;
    logic [63:0]      w_threshold;
    logic             w_fire;

    always_comb begin
        w_threshold = 64'(MAX_WAIT) * (64'(cov >> STALL_SHIFT) + 64'd1);

        if (tohost_done || (cov != r_pre_cov))
            w_stall_next = '0;
        else
            w_stall_next = (&r_stall) ? r_stall : r_stall + 32'd1;

        if (tohost_done)
            w_wdog_next = '0;
        else
            w_wdog_next = (&r_wdog) ? r_wdog : r_wdog + 32'd1;

        w_fire = ({32'd0, w_stall_next} >= w_threshold) ||
                 (w_wdog_next >= 32'(WDOG_LIMIT));
    end

    // pre_cov follows cov outside RUN so a steady probe counts as stalled
    // from the very first RUN cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pre_cov <= '0;
            r_stall   <= '0;
            r_wdog    <= '0;
            r_irq     <= 1'b0;
        end else if (run_en) begin
            r_pre_cov <= cov;
            r_stall   <= w_stall_next;
            r_wdog    <= w_wdog_next;
            r_irq     <= w_fire;
        end else begin
            r_pre_cov <= cov;
            r_stall   <= '0;
            r_wdog    <= '0;
            r_irq     <= 1'b0;
        end
    end

    assign interrupt = r_irq & run_en;

endmodule
`default_nettype wire

// File: rtl/fuzz_round_sequencer.sv
`default_nettype none
// ============================================================================
//  fuzz_round_sequencer
//  Per-round controller: DUT reset, run, pass/timeout detection, report, reload.
//  Revision: 1.0
// ============================================================================
module fuzz_round_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int COV_W       = 30,
    parameter int MAX_WAIT    = 1000,
    parameter int STALL_SHIFT = 19,
    parameter int WDOG_LIMIT  = 50000,
    parameter int RST_CYCLES  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [63:0]      max_cycles,
    input  logic [63:0]      tohost,
    input  logic [COV_W-1:0] cov,
    input  logic             reload_ack,
    input  logic             reload_ok,
    output logic             dut_reset,
    output logic             interrupt,
    output logic             reload_req,
    output logic             round_done,
    output logic [2:0]       round_status,
    output logic [63:0]      cycle_count,
    output logic             busy
);

    localparam int c_RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [c_RST_CNT_W-1:0] c_RST_LAST = c_RST_CNT_W'(RST_CYCLES - 1);

    seq_state_t             r_state;
    seq_state_t             w_next_state;
    logic [c_RST_CNT_W-1:0] r_rst_cnt;
    logic [63:0]            r_cycle_count;
    logic [2:0]             r_status;

    logic [63:0]            w_cycle_next;
    logic                   w_pass;
    logic                   w_timeout;
    logic                   w_unused_tohost;

    assign w_unused_tohost = ^tohost[63:1];

    // Timeout compares the count including the current cycle, so a round
    // with limit N spends exactly N cycles in RUN.
    always_comb begin
        w_next_state = r_state;
        w_cycle_next = sat_inc64(r_cycle_count);
        w_pass       = tohost[0];
        w_timeout    = (max_cycles != 64'd0) && (w_cycle_next >= max_cycles);

        case (r_state)
            IDLE:    if (start) w_next_state = RST;
            RST:     if (r_rst_cnt == c_RST_LAST) w_next_state = RUN;
            RUN:     if (w_pass || w_timeout) w_next_state = REPORT;
            REPORT:  w_next_state = RELOAD;
            RELOAD:  if (reload_ack) w_next_state = reload_ok ? RST : HALT;
            HALT:    w_next_state = HALT;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rst_cnt     <= '0;
            r_cycle_count <= '0;
            r_status      <= ST_NONE;
        end else begin
            r_state   <= w_next_state;
            r_rst_cnt <= (r_state == RST) ? r_rst_cnt + c_RST_CNT_W'(1) : '0;

            if (w_next_state == RST)
                r_cycle_count <= '0;
            else if (r_state == RUN)
                r_cycle_count <= w_cycle_next;

            if ((r_state == RUN) && (w_pass || w_timeout))
                r_status <= w_pass ? ST_PASS : ST_TIMEOUT;
        end
    end

    stall_watchdog #(
        .COV_W       (COV_W),
        .MAX_WAIT    (MAX_WAIT),
        .STALL_SHIFT (STALL_SHIFT),
        .WDOG_LIMIT  (WDOG_LIMIT)
    ) u_stall_watchdog (
        .clock       (clock),
        .reset       (reset),
        .run_en      (r_state == RUN),
        .tohost_done (tohost[0]),
        .cov         (cov),
        .interrupt   (interrupt)
    );

    assign dut_reset    = (r_state != RUN);
    assign round_done   = (r_state == REPORT);
    assign reload_req   = (r_state == RELOAD);
    assign busy         = (r_state != IDLE) && (r_state != HALT);
    assign round_status = r_status;
    assign cycle_count  = r_cycle_count;

endmodule
`default_nettype wire

// File: tb/tb_fuzz_round_sequencer.sv
`default_nettype none
// ============================================================================
//  tb_fuzz_round_sequencer
//  Randomized scenario bench for the fuzz round sequencer with a round model.
//  Revision: 1.0
// ============================================================================
module tb_fuzz_round_sequencer;

    localparam int COV_W       = 30;
    localparam int MAX_WAIT    = 1000;
    localparam int STALL_SHIFT = 19;
    localparam int WDOG_LIMIT  = 50000;
    localparam int RST_CYCLES  = 4;
    localparam logic [2:0] EXP_NONE    = 3'd0;
    localparam logic [2:0] EXP_PASS    = 3'd1;
    localparam logic [2:0] EXP_TIMEOUT = 3'd5;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [63:0]      max_cycles = '0;
    logic [63:0]      tohost = '0;
    logic [COV_W-1:0] cov = '0;
    logic             reload_ack = 1'b0;
    logic             reload_ok = 1'b0;
    logic             dut_reset;
    logic             interrupt;
    logic             reload_req;
    logic             round_done;
    logic [2:0]       round_status;
    logic [63:0]      cycle_count;
    logic             busy;

    int checks = 0;
    int errors = 0;

    fuzz_round_sequencer #(
        .COV_W       (COV_W),
        .MAX_WAIT    (MAX_WAIT),
        .STALL_SHIFT (STALL_SHIFT),
        .WDOG_LIMIT  (WDOG_LIMIT),
        .RST_CYCLES  (RST_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .max_cycles   (max_cycles),
        .tohost       (tohost),
        .cov          (cov),
        .reload_ack   (reload_ack),
        .reload_ok    (reload_ok),
        .dut_reset    (dut_reset),
        .interrupt    (interrupt),
        .reload_req   (reload_req),
        .round_done   (round_done),
        .round_status (round_status),
        .cycle_count  (cycle_count),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_round;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (dut_reset === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n != RST_CYCLES) begin
            errors++;
            $display("FAIL %s rst_len: got %0d expected %0d", tag, n, RST_CYCLES);
        end
    endtask

    // Drives one RUN phase and tracks the stall/watchdog rules as plain counts:
    // cycles since the coverage value last changed, cycles since tohost[0].
    task automatic run_phase(input int pass_at, input bit toggle, input int change_at,
                             input int stop_after, output int run_len);
        int               k;
        int               stall_m;
        int               wdog_m;
        bit               exp_irq;
        bit               in_run;
        longint           thr;
        logic [COV_W-1:0] prev_cov;
        k = 0; stall_m = 0; wdog_m = 0; exp_irq = 1'b0; in_run = 1'b1;
        prev_cov = cov;
        while (in_run) begin
            if (dut_reset !== 1'b0) begin
                in_run = 1'b0;
            end else if (k >= 60000) begin
                checks++;
                errors++;
                $display("FAIL run_bound: got %0d cycles expected end of RUN", k);
                in_run = 1'b0;
            end else begin
                k++;
                checks++;
                if (interrupt !== exp_irq) begin
                    errors++;
                    $display("FAIL interrupt run_cycle=%0d: got %b expected %b", k, interrupt, exp_irq);
                end
                tohost = {63'd0, (k == pass_at)};
                if (toggle)
                    cov = cov ^ COV_W'($urandom | 32'd1);
                else if (k == change_at)
                    cov = cov ^ COV_W'(1);
                tick();
                if (tohost[0] || (cov != prev_cov)) stall_m = 0;
                else stall_m++;
                prev_cov = cov;
                wdog_m = tohost[0] ? 0 : wdog_m + 1;
                thr = longint'(MAX_WAIT) * (longint'(cov >> STALL_SHIFT) + 64'sd1);
                exp_irq = (longint'(stall_m) >= thr) || (wdog_m >= WDOG_LIMIT);
                if (stop_after != 0 && k == stop_after) in_run = 1'b0;
            end
        end
        tohost = '0;
        run_len = k;
    endtask

    task automatic finish_round(input string tag, input logic [2:0] exp_st, input int exp_len,
                                input int run_len, input int ack_delay, input bit ok);
        checks++;
        if (run_len != exp_len) begin
            errors++;
            $display("FAIL %s run_len: got %0d expected %0d", tag, run_len, exp_len);
        end
        checks++;
        if (round_done !== 1'b1) begin
            errors++;
            $display("FAIL %s round_done_pulse: got %b expected 1", tag, round_done);
        end
        checks++;
        if (round_status !== exp_st) begin
            errors++;
            $display("FAIL %s round_status: got %0d expected %0d", tag, round_status, exp_st);
        end
        checks++;
        if (cycle_count !== 64'(exp_len)) begin
            errors++;
            $display("FAIL %s cycle_count: got %0d expected %0d", tag, cycle_count, exp_len);
        end
        checks++;
        if ({dut_reset, interrupt, reload_req} !== 3'b100) begin
            errors++;
            $display("FAIL %s report_outputs: got %b expected 100", tag, {dut_reset, interrupt, reload_req});
        end
        // an ack offered during REPORT must be ignored
        reload_ack = 1'b1;
        reload_ok  = 1'b0;
        tick();
        reload_ack = 1'b0;
        checks++;
        if ({round_done, reload_req, busy} !== 3'b011) begin
            errors++;
            $display("FAIL %s reload_entry: got %b expected 011", tag, {round_done, reload_req, busy});
        end
        checks++;
        if (round_status !== exp_st || cycle_count !== 64'(exp_len)) begin
            errors++;
            $display("FAIL %s result_hold: got %0d/%0d expected %0d/%0d",
                     tag, round_status, cycle_count, exp_st, exp_len);
        end
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            checks++;
            if (reload_req !== 1'b1) begin
                errors++;
                $display("FAIL %s reload_req_held: got %b expected 1", tag, reload_req);
            end
        end
        reload_ack = 1'b1;
        reload_ok  = ok;
        tick();
        reload_ack = 1'b0;
        reload_ok  = 1'($urandom);
        checks++;
        if (reload_req !== 1'b0) begin
            errors++;
            $display("FAIL %s reload_req_drop: got %b expected 0", tag, reload_req);
        end
        checks++;
        if (ok) begin
            if ({busy, dut_reset} !== 2'b11 || cycle_count !== 64'd0) begin
                errors++;
                $display("FAIL %s new_round: got busy/rst=%b count=%0d expected 11/0",
                         tag, {busy, dut_reset}, cycle_count);
            end
        end else begin
            if ({busy, dut_reset} !== 2'b01) begin
                errors++;
                $display("FAIL %s halt_entry: got busy/rst=%b expected 01", tag, {busy, dut_reset});
            end
        end
    endtask

    // Round outcome straight from the rules: first of pass cycle or limit, pass wins ties.
    task automatic do_round(input string tag, input int pass_at, input int maxc, input bit toggle,
                            input int change_at, input int ack_delay, input bit ok);
        int         len;
        int         exp_len;
        logic [2:0] exp_st;
        max_cycles = 64'(maxc);
        if (pass_at != 0 && (maxc == 0 || pass_at <= maxc)) begin
            exp_st = EXP_PASS; exp_len = pass_at;
        end else begin
            exp_st = EXP_TIMEOUT; exp_len = maxc;
        end
        wait_run(tag);
        run_phase(pass_at, toggle, change_at, 0, len);
        finish_round(tag, exp_st, exp_len, len, ack_delay, ok);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({dut_reset, interrupt, reload_req, round_done, busy} !== 5'b10000 ||
            round_status !== EXP_NONE || cycle_count !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b status=%0d count=%0d expected 10000/0/0",
                     {dut_reset, interrupt, reload_req, round_done, busy}, round_status, cycle_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_pass_basic;
        start_round();
        do_round("pass100", 100, 0, 1'b1, 0, 7, 1'b1);
    endtask

    task automatic test_timeout;
        do_round("timeout50", 0, 50, 1'b1, 0, $urandom_range(0, 5), 1'b1);
        do_round("pass_priority", 37, 37, 1'b1, 0, 0, 1'b1);
        do_round("no_limit", 400, 0, 1'b1, 0, 2, 1'b1);
    endtask

    task automatic test_random_rounds;
        int pass_at;
        int maxc;
        for (int r = 0; r < 6; r++) begin
            pass_at = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 300));
            maxc    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
            if (pass_at == 0 && maxc == 0) maxc = int'($urandom_range(1, 300));
            do_round("random", pass_at, maxc, 1'b1, 0, $urandom_range(0, 10), 1'b1);
        end
    endtask

    task automatic test_stall;
        cov = '0;
        do_round("stall_base", 1006, 0, 1'b0, 1004, 1, 1'b1);
        cov = COV_W'(32'h0008_0000 | ($urandom & 32'h0007_FFFF));
        do_round("stall_scaled", 2006, 0, 1'b0, 2004, 1, 1'b1);
    endtask

    task automatic test_watchdog;
        do_round("watchdog", 0, 50005, 1'b1, 0, 0, 1'b1);
    endtask

    task automatic test_halt;
        do_round("halt", 20, 0, 1'b1, 0, 3, 1'b0);
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({busy, dut_reset, reload_req} !== 3'b010) begin
                errors++;
                $display("FAIL halt_sticky: got %b expected 010", {busy, dut_reset, reload_req});
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        int len;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        cov = '0;
        max_cycles = '0;
        start_round();
        wait_run("midrun");
        run_phase(0, 1'b0, 0, 1005, len);
        checks++;
        if (interrupt !== 1'b1 || dut_reset !== 1'b0) begin
            errors++;
            $display("FAIL midrun_irq_before_reset: got irq/rst=%b expected 10", {interrupt, dut_reset});
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({dut_reset, interrupt, reload_req, round_done, busy} !== 5'b10000 ||
            round_status !== EXP_NONE || cycle_count !== 64'd0) begin
            errors++;
            $display("FAIL midrun_reset_state: got flags=%b status=%0d count=%0d expected 10000/0/0",
                     {dut_reset, interrupt, reload_req, round_done, busy}, round_status, cycle_count);
        end
        tick();
        start_round();
        wait_run("after_reset");
        run_phase(0, 1'b0, 0, 20, len);
        checks++;
        if (cycle_count !== 64'd20) begin
            errors++;
            $display("FAIL after_reset_count: got %0d expected 20", cycle_count);
        end
    endtask

    initial begin
        test_reset();
        test_pass_basic();
        test_timeout();
        test_random_rounds();
        test_stall();
        test_watchdog();
        test_halt();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
